// File: rtl/dec_mux_unit.sv
// Binary-to-one-hot decoder plus N-way data multiplexer, each with a combinational
// output and a one-cycle registered copy cleared by an asynchronous reset.
module dec_mux_unit #(
    parameter int N_SEL_BITS  = 5,
    parameter int NUM_OPTIONS = 32,
    parameter int DATA_WIDTH  = 32,
    localparam int SW         = (NUM_OPTIONS > 1) ? $clog2(NUM_OPTIONS) : 1,
    localparam int N_OUT      = 2 ** N_SEL_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_SEL_BITS-1:0] i_sel,
    output logic [N_OUT-1:0]      o,
    output logic [N_OUT-1:0]      o_q,
    input  logic [SW-1:0]         i_mux_sel,
    input  logic [DATA_WIDTH-1:0] i_val [0:NUM_OPTIONS-1],
    output logic [DATA_WIDTH-1:0] o_val,
    output logic [DATA_WIDTH-1:0] o_val_q
);

    logic [N_OUT-1:0]      o_q_reg;
    logic [DATA_WIDTH-1:0] o_val_q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_dec
            assign o[gi] = (i_sel == N_SEL_BITS'(gi));
        end
    endgenerate

    // Explicit compare per option keeps out-of-range selects at zero instead of X.
    always_comb begin
        o_val = '0;
        for (int k = 0; k < NUM_OPTIONS; k++) begin
            if (i_mux_sel == SW'(k)) begin
                o_val = i_val[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q_reg     <= '0;
            o_val_q_reg <= '0;
        end else begin
            o_q_reg     <= o;
            o_val_q_reg <= o_val;
        end
    end

    assign o_q     = o_q_reg;
    assign o_val_q = o_val_q_reg;

endmodule

// File: tb/tb_dec_mux_unit.sv
// Scoreboard bench for dec_mux_unit: default build plus 5-option and 1-option builds.
module tb_dec_mux_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;

    // Default instance: 5 select bits, 32 options, 32-bit data
    logic [4:0]  i_sel = '0;
    logic [31:0] o, o_q;
    logic [4:0]  i_mux_sel = '0;
    logic [31:0] i_val [0:31];
    logic [31:0] o_val, o_val_q;

    // Narrow instance: 3 select bits, 5 options, 8-bit data
    logic [2:0]  sel5 = '0;
    logic [7:0]  o5, o5_q;
    logic [2:0]  msel5 = '0;
    logic [7:0]  val5 [0:4];
    logic [7:0]  oval5, oval5_q;

    // Single-option instance
    logic [0:0]  sel1 = '0;
    logic [1:0]  o1, o1_q;
    logic [0:0]  msel1 = '0;
    logic [7:0]  val1 [0:0];
    logic [7:0]  oval1, oval1_q;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] dec;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    logic [31:0] model_val [0:31];

    always #5 i_clk = ~i_clk;

    dec_mux_unit #(.N_SEL_BITS(5), .NUM_OPTIONS(32), .DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sel(i_sel), .o(o), .o_q(o_q),
        .i_mux_sel(i_mux_sel), .i_val(i_val), .o_val(o_val), .o_val_q(o_val_q)
    );

    dec_mux_unit #(.N_SEL_BITS(3), .NUM_OPTIONS(5), .DATA_WIDTH(8)) dut5 (
        .i_clk(i_clk), .i_rst(i_rst), .i_sel(sel5), .o(o5), .o_q(o5_q),
        .i_mux_sel(msel5), .i_val(val5), .o_val(oval5), .o_val_q(oval5_q)
    );

    dec_mux_unit #(.N_SEL_BITS(1), .NUM_OPTIONS(1), .DATA_WIDTH(8)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_sel(sel1), .o(o1), .o_q(o1_q),
        .i_mux_sel(msel1), .i_val(val1), .o_val(oval1), .o_val_q(oval1_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive both selects, check combinational outputs, queue the registered expectation,
    // then after the next edge pop and compare against the registered outputs.
    task automatic step(input int sel, input int msel);
        exp_t e;
        exp_t got;
        i_sel     = 5'(sel);
        i_mux_sel = 5'(msel);
        #1;
        e.dec = 32'h1 << sel;
        e.val = model_val[msel];
        chk("o", {32'h0, o}, {32'h0, e.dec});
        chk("o_val", {32'h0, o_val}, {32'h0, e.val});
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            chk("o_q", {32'h0, o_q}, {32'h0, got.dec});
            chk("o_val_q", {32'h0, o_val_q}, {32'h0, got.val});
        end
        $display("txn sel=%0d msel=%0d o=%h o_q=%h o_val=%h o_val_q=%h",
                 sel, msel, o, o_q, o_val, o_val_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp8;
        for (int k = 0; k < 32; k++) begin
            model_val[k] = 32'hA500_0000 + 32'(k);
            i_val[k]     = model_val[k];
        end
        for (int k = 0; k < 5; k++) val5[k] = 8'h30 + 8'(k);
        val1[0] = 8'h5A;

        // Reset state: registered outputs zero, combinational live
        #2;
        chk("rst_o_q", {32'h0, o_q}, 64'h0);
        chk("rst_o_val_q", {32'h0, o_val_q}, 64'h0);
        chk("rst_o", {32'h0, o}, 64'h1);
        chk("rst_o_val", {32'h0, o_val}, 64'hA500_0000);
        @(posedge i_clk);
        #1;
        chk("rst_hold_o_q", {32'h0, o_q}, 64'h0);
        i_rst = 1'b0;

        // Decoder and mux sweeps (both selects change together each step)
        for (int s = 0; s < 32; s++) step(s, 31 - s);
        chk("dec_sel0", {32'h0, o}, {32'h0, 32'h8000_0000});
        step(0, 0);
        chk("dec_lo", {32'h0, o_q}, 64'h1);
        for (int n = 0; n < 16; n++) step($urandom_range(0, 31), $urandom_range(0, 31));

        // Async reset mid-cycle
        model_val[7] = 32'hDEAD_BEEF;
        i_val[7]     = 32'hDEAD_BEEF;
        step(4, 7);
        #3;
        i_rst = 1'b1;
        #1;
        chk("arst_o_q", {32'h0, o_q}, 64'h0);
        chk("arst_o_val_q", {32'h0, o_val_q}, 64'h0);
        chk("arst_o", {32'h0, o}, 64'h10);
        chk("arst_o_val", {32'h0, o_val}, 64'hDEAD_BEEF);
        @(posedge i_clk);
        #1;
        chk("arst_hold", {32'h0, o_q}, 64'h0);

        // Release: first edge captures current selects
        i_sel     = 5'd3;
        i_mux_sel = 5'd2;
        #2;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        chk("rel_o_q", {32'h0, o_q}, 64'h8);
        chk("rel_o_val_q", {32'h0, o_val_q}, {32'h0, model_val[2]});

        // Narrow instance: out-of-range selects give zero
        for (int m = 0; m < 8; m++) begin
            sel5  = 3'(m);
            msel5 = 3'(m);
            #1;
            exp8 = (m < 5) ? val5[m] : 8'h00;
            chk("o5", {56'h0, o5}, {56'h0, 8'h1 << m});
            chk("oval5", {56'h0, oval5}, {56'h0, exp8});
            @(posedge i_clk);
            #1;
            chk("oval5_q", {56'h0, oval5_q}, {56'h0, exp8});
            $display("txn5 msel=%0d oval=%h oval_q=%h", m, oval5, oval5_q);
        end

        // Single-option instance
        for (int m = 0; m < 2; m++) begin
            sel1  = 1'(m);
            msel1 = 1'(m);
            #1;
            exp8 = (m == 0) ? 8'h5A : 8'h00;
            chk("o1", {62'h0, o1}, {62'h0, 2'(1 << m)});
            chk("oval1", {56'h0, oval1}, {56'h0, exp8});
            @(posedge i_clk);
            #1;
            chk("oval1_q", {56'h0, oval1_q}, {56'h0, exp8});
            $display("txn1 msel=%0d oval=%h oval_q=%h", m, oval1, oval1_q);
        end

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
